// File: rtl/imm_encode_unit_if.sv
// ----------------------------------------------------------------------------
// imm_encode_unit_if
//   Bundles the request side, the response (FIFO head) side and the status
//   outputs of imm_encode_unit into one interface.
//
//   Request side  : in_valid, in_ready, in_fmt, in_base, in_imm
//   Response side : out_valid, out_ready, out_instr, out_err
//   Status        : level (FIFO occupancy), err_cnt (saturating error count)
//
//   master : the agent that issues requests and consumes encoded words
//   slave  : the encoder itself
// ----------------------------------------------------------------------------
interface imm_encode_unit_if #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    // Request
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_fmt;
    logic [31:0]      in_base;
    logic [31:0]      in_imm;

    // Response
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;

    // Status
    logic [LVL_W-1:0] level;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, in_fmt, in_base, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err, level, err_cnt
    );

    modport slave (
        input  in_valid, in_fmt, in_base, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err, level, err_cnt
    );
endinterface

// File: rtl/imm_encode_unit.sv
// ----------------------------------------------------------------------------
// imm_encode_unit
//   Inverse of the datapath immediate extender. A signed 32-bit immediate is
//   scattered into the I/S/B/J immediate bit positions of a base instruction,
//   range/alignment checked, and queued in a DEPTH-entry FIFO. Decoding the
//   queued word with immsrc = in_fmt returns in_imm whenever out_err = 0.
//
//   Ports
//     clk    : rising-edge clock
//     reset  : asynchronous, active-high reset (empties FIFO, clears err_cnt)
//     bus    : imm_encode_unit_if.slave
//       in_valid/in_ready          request handshake
//       in_fmt                     00 I, 01 S, 10 B, 11 J
//       in_base                    instruction; immediate positions ignored
//       in_imm                     signed immediate to encode
//       out_valid/out_ready        FIFO head handshake
//       out_instr/out_err          head entry (both 0 when empty)
//       level                      FIFO occupancy
//       err_cnt                    accepted erroneous entries, saturating
// ----------------------------------------------------------------------------
module imm_encode_unit #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    imm_encode_unit_if.slave bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        FMT_I = 2'b00,
        FMT_S = 2'b01,
        FMT_B = 2'b10,
        FMT_J = 2'b11
    } fmt_e;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } entry_t;

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------
    fmt_e        fmt;
    logic [31:0] imm;
    entry_t      enc;

    // The immediate fits a format when every bit above the format's sign
    // bit replicates that sign bit.
    logic fits_12;  // I/S: imm[31:11] all equal
    logic fits_13;  // B  : imm[31:12] all equal
    logic fits_21;  // J  : imm[31:20] all equal

    assign fmt     = fmt_e'(bus.in_fmt);
    assign imm     = bus.in_imm;
    assign fits_12 = (imm[31:11] == {21{imm[11]}});
    assign fits_13 = (imm[31:12] == {20{imm[12]}});
    assign fits_21 = (imm[31:20] == {12{imm[20]}});

    // NOTE: every variable driven in an always_comb gets a default on entry,
    // so no path through the case leaves it unassigned and no latch appears.
    always_comb begin
        // Start from the base word; each format overwrites only its
        // immediate fields, so every other base bit passes straight through.
        enc.instr = bus.in_base;
        enc.err   = 1'b0;
        unique case (fmt)
            FMT_I: begin
                enc.instr[31:20] = imm[11:0];
                enc.err          = !fits_12;
            end
            FMT_S: begin
                enc.instr[31:25] = imm[11:5];
                enc.instr[11:7]  = imm[4:0];
                enc.err          = !fits_12;
            end
            FMT_B: begin
                enc.instr[31]    = imm[12];
                enc.instr[30:25] = imm[10:5];
                enc.instr[11:8]  = imm[4:1];
                enc.instr[7]     = imm[11];
                enc.err          = !fits_13 || imm[0];
            end
            FMT_J: begin
                enc.instr[31]    = imm[20];
                enc.instr[30:21] = imm[10:1];
                enc.instr[20]    = imm[11];
                enc.instr[19:12] = imm[19:12];
                enc.err          = !fits_21 || imm[0];
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic in_ready;
    logic out_valid;
    logic push;
    logic pop;

    // in_ready depends on registered occupancy only: a pop in the same cycle
    // does not open a slot until the following cycle.
    assign in_ready  = (level_q != FULL_LVL);
    assign out_valid = (level_q != '0);
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        err_cnt_d = err_cnt_q;

        if (push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end

        // Simultaneous push and pop leave the occupancy unchanged.
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (push && enc.err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // NOTE: the storage array carries no reset; an entry is only ever read
    // after it has been written, and level_q masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enc;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    entry_t head;

    assign head          = mem_q[rd_ptr_q];
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_instr = out_valid ? head.instr : 32'h0;
    assign bus.out_err   = out_valid ? head.err   : 1'b0;
    assign bus.level     = level_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_encode_unit.sv
// ----------------------------------------------------------------------------
// tb_imm_encode_unit
//   Directed and randomised stimulus for imm_encode_unit (DEPTH=2, CNT_W=16).
//   A queue-based model computes encodings with shift/mask arithmetic and
//   error flags with signed range comparisons; a compare process checks every
//   DUT output against it each cycle, and a reference immediate extender
//   confirms the round-trip property on every popped entry.
// ----------------------------------------------------------------------------
module tb_imm_encode_unit;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    localparam logic [1:0] F_I = 2'b00;
    localparam logic [1:0] F_S = 2'b01;
    localparam logic [1:0] F_B = 2'b10;
    localparam logic [1:0] F_J = 2'b11;

    logic clk = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    imm_encode_unit_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    imm_encode_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    function automatic logic [31:0] model_enc(input logic [1:0] f, input logic [31:0] b,
                                              input logic [31:0] i);
        case (f)
            F_I: return (b & 32'h000F_FFFF) | ((i & 32'hFFF) << 20);
            F_S: return (b & 32'h01FF_F07F) | (((i >> 5) & 32'h7F) << 25)
                        | ((i & 32'h1F) << 7);
            F_B: return (b & 32'h01FF_F07F) | (((i >> 12) & 32'h1) << 31)
                        | (((i >> 5) & 32'h3F) << 25) | (((i >> 1) & 32'hF) << 8)
                        | (((i >> 11) & 32'h1) << 7);
            default: return (b & 32'h0000_0FFF) | (((i >> 20) & 32'h1) << 31)
                        | (((i >> 1) & 32'h3FF) << 21) | (((i >> 11) & 32'h1) << 20)
                        | (((i >> 12) & 32'hFF) << 12);
        endcase
    endfunction

    function automatic logic model_err(input logic [1:0] f, input logic [31:0] i);
        int s;
        s = $signed(i);
        case (f)
            F_I, F_S: return (s < -2048) || (s > 2047);
            F_B:      return (s < -4096) || (s > 4095) || (s % 2 != 0);
            default:  return (s < -(1 << 20)) || (s > (1 << 20) - 1) || (s % 2 != 0);
        endcase
    endfunction

    // Reference immediate extender (immsrc decode of the datapath).
    function automatic logic [31:0] ref_decode(input logic [1:0] f, input logic [31:0] w);
        case (f)
            F_I: return {{20{w[31]}}, w[31:20]};
            F_S: return {{20{w[31]}}, w[31:25], w[11:7]};
            F_B: return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            default: return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
        endcase
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [1:0]  fmt;
        logic [31:0] imm;
    } exp_t;

    exp_t             q[$];
    logic [CNT_W-1:0] m_cnt = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_cnt <= '0;
        end else begin
            bit   m_push, m_pop;
            exp_t e;
            m_push = bus.in_valid && (q.size() != DEPTH);
            m_pop  = bus.out_ready && (q.size() != 0);
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                e.instr = model_enc(bus.in_fmt, bus.in_base, bus.in_imm);
                e.err   = model_err(bus.in_fmt, bus.in_imm);
                e.fmt   = bus.in_fmt;
                e.imm   = bus.in_imm;
                q.push_back(e);
                if (e.err && m_cnt != {CNT_W{1'b1}}) m_cnt <= m_cnt + 1'b1;
            end
        end
    end

    // Compare process: outputs are settled mid-cycle.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("in_ready",  bus.in_ready,  q.size() != DEPTH);
            check("out_valid", bus.out_valid, q.size() != 0);
            check("level",     bus.level,     q.size());
            check("err_cnt",   bus.err_cnt,   m_cnt);
            check("out_instr", bus.out_instr, (q.size() != 0) ? q[0].instr : 32'h0);
            check("out_err",   bus.out_err,   (q.size() != 0) ? q[0].err : 1'b0);
            if (bus.out_valid && bus.out_ready && q.size() != 0) begin
                check("roundtrip",
                      ref_decode(q[0].fmt, bus.out_instr) == q[0].imm, !q[0].err);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called just after a rising edge)
    // ------------------------------------------------------------------
    task automatic send(input logic [1:0] f, input logic [31:0] b, input logic [31:0] i);
        bit done = 1'b0;
        int t    = 0;
        bus.in_valid = 1'b1;
        bus.in_fmt   = f;
        bus.in_base  = b;
        bus.in_imm   = i;
        while (!done && t < 50) begin
            @(negedge clk);
            done = bus.in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        bus.in_valid = 1'b0;
        if (!done) check("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain();
        int t = 0;
        bus.out_ready = 1'b1;
        while (bus.out_valid && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        bus.out_ready = 1'b0;
        if (bus.out_valid) check("drain_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_fmt    = F_I;
        bus.in_base   = 32'h0;
        bus.in_imm    = 32'h0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;

        // Pin the model against hand-computed encodings.
        check("model_pin_I", model_enc(F_I, 32'h0000_0513, 32'hFFFF_FFFF), 32'hFFF0_0513);
        check("model_pin_B", model_enc(F_B, 32'h0000_0063, 32'hFFFF_FFFC), 32'hFE00_0EE3);
        check("model_pin_J", model_enc(F_J, 32'h0000_006F, 32'h0000_0800), 32'h0010_006F);
        check("model_pin_err", model_err(F_I, 32'h0000_0800), 1'b1);

        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_in_ready",  bus.in_ready,  1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_level",     bus.level,     2'd0);
        check("rst_err_cnt",   bus.err_cnt,   16'd0);
        check("rst_out_instr", bus.out_instr, 32'h0);

        // 1: I-format, valid one edge after accept
        send(F_I, 32'h0000_0513, 32'hFFFF_FFFF);
        check("t1_valid", bus.out_valid, 1'b1);
        check("t1_instr", bus.out_instr, 32'hFFF0_0513);
        check("t1_err",   bus.out_err,   1'b0);
        drain();

        // 2: B and J
        send(F_B, 32'h0000_0063, 32'hFFFF_FFFC);
        check("t2_b_instr", bus.out_instr, 32'hFE00_0EE3);
        check("t2_b_err",   bus.out_err,   1'b0);
        drain();
        send(F_J, 32'h0000_006F, 32'h0000_0800);
        check("t2_j_instr", bus.out_instr, 32'h0010_006F);
        check("t2_j_err",   bus.out_err,   1'b0);
        drain();

        // 3: out-of-range I, misaligned B
        send(F_I, 32'h0000_0013, 32'h0000_0800);
        check("t3_i_instr", bus.out_instr, 32'h8000_0013);
        check("t3_i_err",   bus.out_err,   1'b1);
        check("t3_i_cnt",   bus.err_cnt,   16'd1);
        drain();
        send(F_B, 32'h0000_0063, 32'h0000_0003);
        check("t3_b_err", bus.out_err, 1'b1);
        check("t3_b_cnt", bus.err_cnt, 16'd2);
        drain();

        // 4: fill, back-pressure, then simultaneous push/pop
        send(F_I, 32'h0000_0013, 32'd1);
        send(F_I, 32'h0000_0013, 32'd2);
        bus.in_valid = 1'b1;
        bus.in_fmt   = F_I;
        bus.in_base  = 32'h0000_0013;
        bus.in_imm   = 32'd3;
        repeat (2) @(posedge clk);
        #1;
        check("t4_full_ready", bus.in_ready,  1'b0);
        check("t4_full_level", bus.level,     2'd2);
        check("t4_head_first", bus.out_instr, 32'h0010_0013);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_pop_level", bus.level,     2'd1);
        check("t4_pop_head",  bus.out_instr, 32'h0020_0013);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("t4_pushpop_level", bus.level,     2'd1);
        check("t4_pushpop_head",  bus.out_instr, 32'h0030_0013);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("t4_empty", bus.out_valid, 1'b0);

        // 5: asynchronous reset between edges
        send(F_I, 32'h0000_0013, 32'hFFFF_F800);
        check("t5_level_before", bus.level, 2'd1);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_valid", bus.out_valid, 1'b0);
        check("t5_rst_level", bus.level,     2'd0);
        check("t5_rst_cnt",   bus.err_cnt,   16'd0);
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        check("t5_post_ready", bus.in_ready,  1'b1);
        check("t5_post_valid", bus.out_valid, 1'b0);

        // 6: random formats/immediates with random back-pressure
        for (int n = 0; n < 400; n++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_fmt    = 2'($urandom_range(0, 3));
            bus.in_base   = $urandom;
            bus.in_imm    = $signed($urandom) >>> $urandom_range(0, 31);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        drain();
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
